ext_rd_arbiter: RTL

//  Round-robin arbiter sharing one external read port between the instruction, feature and weight fetchers.

---
 rtl/ext_rd_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/ext_rd_arbiter.sv
// Round-robin arbiter sharing one external read port between the instruction,
// feature and weight fetchers; returned beats are routed back by an owner tag pipeline.
`timescale 1ns/1ps
module ext_rd_arbiter #(
    parameter int unsigned NUM_REQ    = 3,
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned MAX_BURST  = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ-1:0]            req_rd_en,
    output logic [NUM_REQ-1:0]            gnt,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_rd_en,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          busy
);

    localparam int unsigned OW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned OW1 = OW + 1;
    localparam int unsigned CW  = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, GRANT, DRAIN} state_t;

    state_t        state;
    logic [OW-1:0] owner;
    logic [OW-1:0] rr_ptr;
    logic [OW-1:0] sel;
    logic [OW-1:0] owner_inc;
    logic [OW:0]   cand;
    logic          found;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] cnt_nxt;
    logic          accept;
    logic          release_now;

    logic [RD_LATENCY:0] tag_vld;
    logic [OW-1:0]       tag_own [RD_LATENCY+1];

    // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        sel   = rr_ptr;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_ptr} + OW1'(i);
            if (cand >= OW1'(NUM_REQ)) begin
                cand = cand - OW1'(NUM_REQ);
            end
            if (!found && req[cand[OW-1:0]]) begin
                sel   = cand[OW-1:0];
                found = 1'b1;
            end
        end
    end

    assign owner_inc   = (owner == OW'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
    assign accept      = (state == GRANT) && gnt[owner] && req_rd_en[owner]
                         && (beat_cnt < CW'(MAX_BURST));
    assign cnt_nxt     = beat_cnt + CW'(accept);
    assign release_now = !req[owner] || (cnt_nxt >= CW'(MAX_BURST));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            gnt       <= '0;
            owner     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
        end else begin
            mem_rd_en <= accept;
            if (accept) begin
                mem_addr <= req_addr[owner*ADDR_WIDTH +: ADDR_WIDTH];
            end
            case (state)
                IDLE: begin
                    if (found) begin
                        owner    <= sel;
                        gnt      <= NUM_REQ'(1) << sel;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    beat_cnt <= cnt_nxt;
                    if (release_now) begin
                        gnt    <= '0;
                        rr_ptr <= owner_inc;
                        state  <= DRAIN;
                    end
                end
                DRAIN:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 0 is aligned with mem_rd_en; stage RD_LATENCY with valid mem_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_vld <= '0;
            for (int unsigned k = 0; k <= RD_LATENCY; k++) begin
                tag_own[k] <= '0;
            end
        end else begin
            tag_vld    <= {tag_vld[RD_LATENCY-1:0], accept};
            tag_own[0] <= owner;
            for (int unsigned k = 1; k <= RD_LATENCY; k++) begin
                tag_own[k] <= tag_own[k-1];
            end
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (tag_vld[RD_LATENCY]) begin
            rsp_valid[tag_own[RD_LATENCY]] = 1'b1;
        end
    end

    assign rsp_data = mem_rdata;
    assign busy     = (state != IDLE);

endmodule
